// File: rtl/ltc2333_pkg.sv
// Shared types and field layout for the LTC2333 SDO capture stage.
package ltc2333_pkg;

    localparam int unsigned WORD_BITS   = 24;
    localparam int unsigned RESULT_BITS = 18;
    localparam int unsigned CHAN_BITS   = 3;
    localparam int unsigned SPAN_BITS   = 3;
    localparam int unsigned TDATA_BITS  = 32;

    // Bit offsets inside a 24-bit SDO word (MSB first on the wire)
    localparam int unsigned RESULT_LSB = 6;
    localparam int unsigned CHAN_LSB   = 3;
    localparam int unsigned SPAN_LSB   = 0;

    // Output beat layout: {lane, id_err, chan_id, span, pad, result}
    typedef struct packed {
        logic                   lane;
        logic                   id_err;
        logic [CHAN_BITS-1:0]   chan_id;
        logic [SPAN_BITS-1:0]   span;
        logic [5:0]             pad;
        logic [RESULT_BITS-1:0] result;
    } sample_t;

    typedef enum logic {
        IDLE,
        SHIFT
    } deser_state_t;

endpackage

// File: rtl/ltc2333_sdo_deser_if.sv
// AXI-Stream style result port toward the DAQ/DMA path.
interface ltc2333_sdo_deser_if;
    import ltc2333_pkg::*;

    logic [TDATA_BITS-1:0] m_tdata;
    logic                  m_tvalid;
    logic                  m_tready;

    modport master (
        output m_tdata,
        output m_tvalid,
        input  m_tready
    );

    modport slave (
        input  m_tdata,
        input  m_tvalid,
        output m_tready
    );

endinterface

// File: rtl/ltc2333_sync_fifo.sv
// Single-clock first-word-fall-through FIFO. A write while full succeeds only if a
// read happens in the same cycle. rd_data reads as zero while empty.
module ltc2333_sync_fifo #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 16
) (
    input  logic              clk,
    input  logic              aresetn,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr_q, rd_ptr_q;
    logic              wr_fire, rd_fire;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rd_fire = rd_en && !empty;
    assign wr_fire = wr_en && (!full || rd_fire);
    assign rd_data = empty ? '0 : mem[rd_ptr_q[AW-1:0]];

    // Pointer update; extra MSB distinguishes full from empty
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (wr_fire) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (rd_fire) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end

    // Storage write; contents are masked by empty so no reset is needed
    always_ff @(posedge clk) begin
        if (wr_fire) mem[wr_ptr_q[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/ltc2333_sdo_deser.sv
// Deserialises the per-ADC SDO lanes into tagged result words, checks channel IDs
// against the active-channel sequence and buffers them for a stream consumer.
module ltc2333_sdo_deser #(
    parameter int unsigned NLANE      = 2,
    parameter int unsigned WORD_BITS  = 24,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned NCHAN      = 8
) (
    input  logic                clk,
    input  logic                aresetn,
    input  logic                frame_start,
    input  logic                bit_valid,
    input  logic [NLANE-1:0]    sdo,
    input  logic [NCHAN-1:0]    active_channels,
    ltc2333_sdo_deser_if.master m_axis,
    output logic                busy,
    output logic [15:0]         overflow_cnt,
    output logic [15:0]         abort_cnt
);
    import ltc2333_pkg::*;

    localparam int unsigned CHW = $clog2(NCHAN);
    localparam int unsigned LW  = (NLANE > 1) ? $clog2(NLANE) : 1;
    localparam int unsigned PW  = $clog2(NLANE + 1);

    deser_state_t         state_q, state_d;
    logic [4:0]           bit_cnt_q, bit_cnt_d;
    logic [3:0]           word_cnt_q, word_cnt_d;
    logic [3:0]           n_words_q, n_words_d;
    logic [CHW-1:0]       exp_ptr_q, exp_ptr_d;
    logic [NCHAN-1:0]     mask_q, mask_d;
    logic [WORD_BITS-2:0] sh_q [NLANE];
    logic [WORD_BITS-2:0] sh_d [NLANE];
    logic [WORD_BITS-1:0] word_full [NLANE];
    sample_t              hold_q [NLANE];
    sample_t              hold_d [NLANE];
    logic [PW-1:0]        pend_q, pend_d;
    logic [15:0]          ovf_q, ovf_d, abort_q, abort_d;

    logic [NCHAN-1:0]     mask_eff;
    logic [CHW-1:0]       first_ptr, nxt_ptr;
    logic [3:0]           pop_cnt;
    logic                 word_done;
    logic                 push, pop;
    sample_t              push_data;
    logic [TDATA_BITS-1:0] fifo_rd;
    logic                 fifo_full, fifo_empty;

    assign busy         = (state_q == SHIFT);
    assign overflow_cnt = ovf_q;
    assign abort_cnt    = abort_q;
    assign pop          = m_axis.m_tvalid && m_axis.m_tready;
    assign m_axis.m_tvalid = !fifo_empty;
    assign m_axis.m_tdata  = fifo_rd;

    // Frame setup values from the mask, and the next expected channel after exp_ptr
    always_comb begin
        mask_eff  = (active_channels == '0) ? '1 : active_channels;
        first_ptr = '0;
        pop_cnt   = '0;
        for (int i = NCHAN - 1; i >= 0; i--) begin
            if (mask_eff[i]) first_ptr = CHW'(i);
            pop_cnt = pop_cnt + 4'(mask_eff[i]);
        end
        // Scan far-to-near so the nearest set bit after exp_ptr wins
        nxt_ptr = exp_ptr_q;
        for (int i = NCHAN - 1; i >= 1; i--) begin
            if (mask_q[exp_ptr_q + CHW'(i)]) nxt_ptr = exp_ptr_q + CHW'(i);
        end
    end

    // Completed word per lane: stored bits plus the bit arriving this cycle
    always_comb begin
        for (int l = 0; l < NLANE; l++) word_full[l] = {sh_q[l], sdo[l]};
    end

    // FSM next state and shift/word datapath; frame_start overrides any bit this cycle
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        word_cnt_d = word_cnt_q;
        n_words_d  = n_words_q;
        exp_ptr_d  = exp_ptr_q;
        mask_d     = mask_q;
        sh_d       = sh_q;
        hold_d     = hold_q;
        abort_d    = abort_q;
        word_done  = 1'b0;

        if (frame_start) begin
            if (state_q == SHIFT && abort_q != 16'hFFFF) abort_d = abort_q + 16'd1;
            state_d    = SHIFT;
            bit_cnt_d  = '0;
            word_cnt_d = '0;
            exp_ptr_d  = first_ptr;
            n_words_d  = pop_cnt;
            mask_d     = mask_eff;
        end else if (state_q == SHIFT && bit_valid) begin
            for (int l = 0; l < NLANE; l++) sh_d[l] = {sh_q[l][WORD_BITS-3:0], sdo[l]};
            if (bit_cnt_q == 5'(WORD_BITS - 1)) begin
                word_done  = 1'b1;
                bit_cnt_d  = '0;
                word_cnt_d = word_cnt_q + 4'd1;
                exp_ptr_d  = nxt_ptr;
                for (int l = 0; l < NLANE; l++) begin
                    hold_d[l].lane    = 1'(l);
                    hold_d[l].id_err  = word_full[l][CHAN_LSB +: CHAN_BITS]
                                        != CHAN_BITS'(exp_ptr_q);
                    hold_d[l].chan_id = word_full[l][CHAN_LSB +: CHAN_BITS];
                    hold_d[l].span    = word_full[l][SPAN_LSB +: SPAN_BITS];
                    hold_d[l].pad     = '0;
                    hold_d[l].result  = word_full[l][RESULT_LSB +: RESULT_BITS];
                end
                if (word_cnt_q + 4'd1 == n_words_q) state_d = IDLE;
            end else begin
                bit_cnt_d = bit_cnt_q + 5'd1;
            end
        end
    end

    // Push engine: drains hold[] lane 0 first, one per cycle, counting drops on full
    always_comb begin
        pend_d    = pend_q;
        push      = 1'b0;
        push_data = '0;
        ovf_d     = ovf_q;
        if (pend_q != '0) begin
            push      = 1'b1;
            push_data = hold_q[LW'(NLANE - 32'(pend_q))];
            pend_d    = pend_q - PW'(1);
            // A same-cycle pop frees a slot, so only a stalled full FIFO drops
            if (fifo_full && !pop && ovf_q != 16'hFFFF) ovf_d = ovf_q + 16'd1;
        end
        if (word_done) pend_d = PW'(NLANE);
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            word_cnt_q <= '0;
            n_words_q  <= '0;
            exp_ptr_q  <= '0;
            mask_q     <= '0;
            pend_q     <= '0;
            ovf_q      <= '0;
            abort_q    <= '0;
            for (int l = 0; l < NLANE; l++) begin
                sh_q[l]   <= '0;
                hold_q[l] <= '0;
            end
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            word_cnt_q <= word_cnt_d;
            n_words_q  <= n_words_d;
            exp_ptr_q  <= exp_ptr_d;
            mask_q     <= mask_d;
            pend_q     <= pend_d;
            ovf_q      <= ovf_d;
            abort_q    <= abort_d;
            sh_q       <= sh_d;
            hold_q     <= hold_d;
        end
    end

    ltc2333_sync_fifo #(
        .DATA_W (TDATA_BITS),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .aresetn (aresetn),
        .wr_en   (push),
        .wr_data (push_data),
        .rd_en   (pop),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

endmodule

// File: tb/tb_ltc2333_sdo_deser.sv
// Bench for ltc2333_sdo_deser: word-level model with an expected-beat queue checked
// on every accepted beat, plus directed scenarios and literal pins.
module tb_ltc2333_sdo_deser;

    logic        clk = 1'b0;
    logic        aresetn, frame_start, bit_valid;
    logic [1:0]  sdo;
    logic [7:0]  active_channels;
    logic        busy;
    logic [15:0] overflow_cnt, abort_cnt;

    int          checks = 0;
    int          errors = 0;
    int          ready_mode = 0;
    logic [23:0] lw [2][8];
    logic [31:0] exp_q [$];
    logic [31:0] out_log [256];
    int          out_n = 0;
    int          base;
    int          chs [3];
    logic        stall_q = 1'b0;
    logic [31:0] stall_data = '0;

    always #5 clk = ~clk;

    ltc2333_sdo_deser_if axis_if ();

    ltc2333_sdo_deser #(
        .NLANE      (2),
        .WORD_BITS  (24),
        .FIFO_DEPTH (16),
        .NCHAN      (8)
    ) dut (
        .clk             (clk),
        .aresetn         (aresetn),
        .frame_start     (frame_start),
        .bit_valid       (bit_valid),
        .sdo             (sdo),
        .active_channels (active_channels),
        .m_axis          (axis_if),
        .busy            (busy),
        .overflow_cnt    (overflow_cnt),
        .abort_cnt       (abort_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Expected output beat built directly from the field definitions
    function automatic logic [31:0] exp_out(input int lane, input logic err, input logic [23:0] w);
        return {lane[0], err, w[5:3], w[2:0], 6'b0, w[23:6]};
    endfunction

    // k-th expected channel of a frame: the k-th set bit of the mask (0 = all channels)
    function automatic int exp_chan(input logic [7:0] mask, input int k);
        int lst [8];
        int n = 0;
        logic [7:0] m = (mask == 8'h00) ? 8'hFF : mask;
        for (int i = 0; i < 8; i++) begin
            if (m[i]) begin
                lst[n] = i;
                n++;
            end
        end
        return lst[k % n];
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_word(input logic [7:0] mask, input int k);
        for (int l = 0; l < 2; l++)
            exp_q.push_back(exp_out(l, lw[l][k][5:3] != 3'(exp_chan(mask, k)), lw[l][k]));
    endtask

    task automatic send_bits(input logic [23:0] w0, input logic [23:0] w1, input int nbits,
                             input int gap_max);
        for (int b = 23; b > 23 - nbits; b--) begin
            if (gap_max > 0) repeat ($urandom_range(0, gap_max)) tick();
            bit_valid = 1'b1;
            sdo       = {w1[b], w0[b]};
            tick();
            bit_valid = 1'b0;
        end
    endtask

    // Mask is driven only during the frame_start cycle, then scrambled
    task automatic start_frame(input logic [7:0] mask);
        frame_start     = 1'b1;
        active_channels = mask;
        tick();
        frame_start     = 1'b0;
        active_channels = ~mask;
    endtask

    task automatic send_frame(input logic [7:0] mask, input int nw, input int gap_max,
                              input bit enq);
        start_frame(mask);
        for (int k = 0; k < nw; k++) begin
            send_bits(lw[0][k], lw[1][k], 24, gap_max);
            if (enq) expect_word(mask, k);
            check((k == nw - 1) ? "busy_end" : "busy_mid", {31'b0, busy},
                  (k == nw - 1) ? 32'd0 : 32'd1);
        end
    endtask

    task automatic wait_drain(input string name);
        int i = 0;
        while (exp_q.size() != 0 && i < 3000) begin
            tick();
            i++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
        repeat (4) tick();
        check({name, "_idle"}, {31'b0, axis_if.m_tvalid}, 32'd0);
    endtask

    task automatic fill_seq(input int off, input logic [2:0] span);
        for (int k = 0; k < 8; k++)
            for (int l = 0; l < 2; l++)
                lw[l][k] = {18'(k * 1000 + l + off), 3'(k), span};
    endtask

    // Ready pattern, updated just after each rising edge
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       axis_if.m_tready = 1'b1;
            1:       axis_if.m_tready = 1'b0;
            default: axis_if.m_tready = 1'($urandom_range(0, 1));
        endcase
    end

    // Scoreboard compare on every accepted beat, plus hold-while-stalled check
    always @(negedge clk) begin
        if (stall_q) begin
            check("stall_valid", {31'b0, axis_if.m_tvalid}, 32'd1);
            check("stall_data", axis_if.m_tdata, stall_data);
        end
        if (aresetn === 1'b1 && axis_if.m_tvalid === 1'b1 && axis_if.m_tready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat actual=%h required=none", axis_if.m_tdata);
            end else begin
                check("stream", axis_if.m_tdata, exp_q.pop_front());
            end
            if (out_n < 256) out_log[out_n] = axis_if.m_tdata;
            out_n++;
        end
        stall_q    = (aresetn === 1'b1) && (axis_if.m_tvalid === 1'b1)
                     && (axis_if.m_tready === 1'b0);
        stall_data = axis_if.m_tdata;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        aresetn = 1'b0; frame_start = 1'b0; bit_valid = 1'b0; sdo = '0; active_channels = '0;
        tick();
        tick();
        check("rst_tvalid", {31'b0, axis_if.m_tvalid}, 32'd0);
        check("rst_tdata", axis_if.m_tdata, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_ovf", 32'(overflow_cnt), 32'd0);
        check("rst_abort", 32'(abort_cnt), 32'd0);
        aresetn = 1'b1;
        tick();

        // 1: full mask, 8 words per lane
        fill_seq(0, 3'b011);
        send_frame(8'hFF, 8, 0, 1);
        wait_drain("t1_drain");
        check("t1_lit0", out_log[0], 32'h0300_0000);
        check("t1_lit3", out_log[3], 32'h8B00_03E9);

        // 2: sparse mask, matching then mismatching channel IDs
        base = out_n;
        chs = '{2, 5, 7};
        for (int k = 0; k < 3; k++)
            for (int l = 0; l < 2; l++) lw[l][k] = {18'h20000 + 18'(k * 16 + l), 3'(chs[k]), 3'b101};
        send_frame(8'b1010_0100, 3, 0, 1);
        chs = '{2, 6, 7};
        for (int k = 0; k < 3; k++)
            for (int l = 0; l < 2; l++) lw[l][k] = {18'h20000 + 18'(k * 16 + l), 3'(chs[k]), 3'b101};
        send_frame(8'b1010_0100, 3, 0, 1);
        wait_drain("t2_drain");
        check("t2_lit_ok", out_log[base + 2], 32'h2D02_0010);
        check("t2_lit_err", out_log[base + 9], 32'hF502_0011);

        // 3: stalled sink, 32 words into a 16-deep FIFO
        ready_mode = 1;
        tick();
        fill_seq(0, 3'b011);
        send_frame(8'hFF, 8, 0, 1);
        send_frame(8'hFF, 8, 0, 0);
        repeat (5) tick();
        check("t3_ovf", 32'(overflow_cnt), 32'd16);
        check("t3_valid", {31'b0, axis_if.m_tvalid}, 32'd1);
        ready_mode = 0;
        wait_drain("t3_drain");
        check("t3_ovf_hold", 32'(overflow_cnt), 32'd16);

        // 4: early frame_start inside word 3
        base = out_n;
        fill_seq(7, 3'b011);
        start_frame(8'hFF);
        for (int k = 0; k < 3; k++) begin
            send_bits(lw[0][k], lw[1][k], 24, 0);
            expect_word(8'hFF, k);
        end
        send_bits(lw[0][3], lw[1][3], 10, 0);
        fill_seq(0, 3'b110);
        send_frame(8'hFF, 8, 0, 1);
        check("t4_abort", 32'(abort_cnt), 32'd1);
        wait_drain("t4_drain");
        check("t4_lit", out_log[base + 6], 32'h0600_0000);

        // 5: one-cycle reset mid-word with a non-empty FIFO
        ready_mode = 1;
        tick();
        fill_seq(3, 3'b001);
        start_frame(8'hFF);
        send_bits(lw[0][0], lw[1][0], 24, 0);
        send_bits(lw[0][1], lw[1][1], 24, 0);
        send_bits(lw[0][2], lw[1][2], 5, 0);
        tick();
        check("t5_pre_valid", {31'b0, axis_if.m_tvalid}, 32'd1);
        aresetn = 1'b0;
        tick();
        aresetn = 1'b1;
        check("t5_tvalid", {31'b0, axis_if.m_tvalid}, 32'd0);
        check("t5_busy", {31'b0, busy}, 32'd0);
        check("t5_ovf", 32'(overflow_cnt), 32'd0);
        check("t5_abort", 32'(abort_cnt), 32'd0);
        ready_mode = 0;
        tick();
        send_frame(8'hFF, 8, 0, 1);
        wait_drain("t5_drain");

        // 6: random bit gaps and random ready, several masks
        ready_mode = 2;
        for (int k = 0; k < 8; k++)
            for (int l = 0; l < 2; l++) lw[l][k] = 24'($urandom);
        send_frame(8'hFF, 8, 5, 1);
        for (int k = 0; k < 3; k++) begin
            for (int l = 0; l < 2; l++) lw[l][k] = 24'($urandom);
            lw[0][k][5:3] = 3'(exp_chan(8'b0100_1001, k));
        end
        send_frame(8'b0100_1001, 3, 5, 1);
        for (int k = 0; k < 8; k++)
            for (int l = 0; l < 2; l++) lw[l][k] = 24'($urandom);
        send_frame(8'h00, 8, 5, 1);
        ready_mode = 0;
        wait_drain("t6_drain");
        check("t6_ovf", 32'(overflow_cnt), 32'd0);
        check("t6_abort", 32'(abort_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
